// File: rtl/bus_pkg.sv
// Shared definitions for the data-bus receive side: default width, register
// indices and the conflict counter width.
package bus_pkg;

    localparam int BUS_DATA_W = 16;
    localparam int CONFLICT_CNT_W = 8;

    typedef enum logic [3:0] {
        REG_PC  = 4'd0,
        REG_AR  = 4'd1,
        REG_AC  = 4'd2,
        REG_R   = 4'd3,
        REG_DR  = 4'd4,
        REG_A   = 4'd5,
        REG_B   = 4'd6,
        REG_C   = 4'd7,
        REG_D   = 4'd8,
        REG_TR  = 4'd9,
        REG_CID = 4'd10
    } reg_idx_e;

endpackage

// File: rtl/bus_inc_reg.sv
// Bus destination register with write > clear > increment > hold priority.
// next_val/changed expose the value being written so callers can derive flags.
module bus_inc_reg #(
    parameter int DATA_W  = 16,
    parameter bit HAS_CLR = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d_in,
    input  logic              write_en,
    input  logic              clr_en,
    input  logic              inc_en,
    output logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] next_val,
    output logic              changed
);

    logic [DATA_W-1:0] val_q;
    logic [DATA_W-1:0] val_d;

    // Increment wraps naturally at DATA_W bits; no carry is kept.
    always_comb begin
        val_d   = val_q;
        changed = 1'b1;
        if (write_en) begin
            val_d = d_in;
        end else if (HAS_CLR && clr_en) begin
            val_d = '0;
        end else if (inc_en) begin
            val_d = val_q + DATA_W'(1);
        end else begin
            changed = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q        = val_q;
    assign next_val = val_d;

endmodule

// File: rtl/bus_write_regs.sv
// Destination register bank on the shared data bus, with PC/AR/AC micro-ops.
// Optional write/increment/clear conflict tracking under BUS_WR_CONFLICT_EN.
module bus_write_regs
    import bus_pkg::*;
#(
    parameter int DATA_W  = BUS_DATA_W,
    parameter int CORE_ID = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus,
    input  logic              PC_write_en,
    input  logic              AR_write_en,
    input  logic              AC_write_en,
    input  logic              R_write_en,
    input  logic              DR_write_en,
    input  logic              A_write_en,
    input  logic              B_write_en,
    input  logic              C_write_en,
    input  logic              D_write_en,
    input  logic              TR_write_en,
    input  logic              PC_inc_en,
    input  logic              AR_inc_en,
    input  logic              AC_inc_en,
    input  logic              AC_clr_en,
    output logic [DATA_W-1:0] PC_out,
    output logic [DATA_W-1:0] AR_out,
    output logic [DATA_W-1:0] AC_out,
    output logic [DATA_W-1:0] R_out,
    output logic [DATA_W-1:0] DR_out,
    output logic [DATA_W-1:0] A_out,
    output logic [DATA_W-1:0] B_out,
    output logic [DATA_W-1:0] C_out,
    output logic [DATA_W-1:0] D_out,
    output logic [DATA_W-1:0] TR_out,
    output logic [DATA_W-1:0] CID_out,
    output logic              Z_flag
`ifdef BUS_WR_CONFLICT_EN
    ,
    output logic                      conflict_err,
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`endif
);

    localparam int N_PLAIN = 7;

    logic [DATA_W-1:0] pc_next;
    logic [DATA_W-1:0] ar_next;
    logic [DATA_W-1:0] ac_next;
    logic              pc_changed;
    logic              ar_changed;
    logic              ac_changed;

    logic [N_PLAIN-1:0] plain_we;
    logic [DATA_W-1:0]  plain_q [N_PLAIN];
    logic [DATA_W-1:0]  plain_d [N_PLAIN];

    logic z_q;
    logic z_d;

    bus_inc_reg #(.DATA_W(DATA_W), .HAS_CLR(1'b0)) u_pc (
        .clk      (clk),
        .rst      (rst),
        .d_in     (bus),
        .write_en (PC_write_en),
        .clr_en   (1'b0),
        .inc_en   (PC_inc_en),
        .q        (PC_out),
        .next_val (pc_next),
        .changed  (pc_changed)
    );

    bus_inc_reg #(.DATA_W(DATA_W), .HAS_CLR(1'b0)) u_ar (
        .clk      (clk),
        .rst      (rst),
        .d_in     (bus),
        .write_en (AR_write_en),
        .clr_en   (1'b0),
        .inc_en   (AR_inc_en),
        .q        (AR_out),
        .next_val (ar_next),
        .changed  (ar_changed)
    );

    bus_inc_reg #(.DATA_W(DATA_W), .HAS_CLR(1'b1)) u_ac (
        .clk      (clk),
        .rst      (rst),
        .d_in     (bus),
        .write_en (AC_write_en),
        .clr_en   (AC_clr_en),
        .inc_en   (AC_inc_en),
        .q        (AC_out),
        .next_val (ac_next),
        .changed  (ac_changed)
    );

    // Plain load-enable registers, ordered R, DR, A, B, C, D, TR.
    assign plain_we = {TR_write_en, D_write_en, C_write_en, B_write_en,
                       A_write_en, DR_write_en, R_write_en};

    always_comb begin
        for (int i = 0; i < N_PLAIN; i++) begin
            plain_d[i] = plain_we[i] ? bus : plain_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PLAIN; i++) begin
                plain_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PLAIN; i++) begin
                plain_q[i] <= plain_d[i];
            end
        end
    end

    assign R_out  = plain_q[0];
    assign DR_out = plain_q[1];
    assign A_out  = plain_q[2];
    assign B_out  = plain_q[3];
    assign C_out  = plain_q[4];
    assign D_out  = plain_q[5];
    assign TR_out = plain_q[6];

    // Zero flag tracks the value AC is about to take, so both update together.
    always_comb begin
        z_d = z_q;
        if (ac_changed) begin
            z_d = (ac_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q <= 1'b1;
        end else begin
            z_q <= z_d;
        end
    end

    assign Z_flag  = z_q;
    assign CID_out = DATA_W'(CORE_ID);

`ifdef BUS_WR_CONFLICT_EN
    logic                      conflict;
    logic                      err_q;
    logic                      err_d;
    logic [CONFLICT_CNT_W-1:0] cnt_q;
    logic [CONFLICT_CNT_W-1:0] cnt_d;

    assign conflict = (PC_write_en && PC_inc_en) ||
                      (AR_write_en && AR_inc_en) ||
                      (AC_write_en && AC_inc_en) ||
                      ((AC_write_en || AC_inc_en) && AC_clr_en);

    // Sticky error plus a saturating count of conflicting cycles.
    always_comb begin
        err_d = err_q | conflict;
        cnt_d = cnt_q;
        if (conflict && (cnt_q != '1)) begin
            cnt_d = cnt_q + CONFLICT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign conflict_err = err_q;
    assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_bus_write_regs.sv
// Self-checking bench for bus_write_regs: directed scenarios followed by
// randomized micro-operations compared against a register-level model.
module tb_bus_write_regs;

    localparam int DW      = 16;
    localparam int CORE_ID = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] bus;
    logic [9:0]    we_s;
    logic [2:0]    ie_s;
    logic          clr_s;

    logic [DW-1:0] PC_out, AR_out, AC_out, R_out, DR_out;
    logic [DW-1:0] A_out, B_out, C_out, D_out, TR_out, CID_out;
    logic          Z_flag;
    logic [DW-1:0] dut_out [10];
`ifdef BUS_WR_CONFLICT_EN
    logic          conflict_err;
    logic [7:0]    conflict_cnt;
`endif

    // Reference model: registers indexed PC, AR, AC, R, DR, A, B, C, D, TR.
    logic [DW-1:0] mdl [10];
    logic          m_z;
    logic          m_err;
    int            m_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_write_regs #(.DATA_W(DW), .CORE_ID(CORE_ID)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .PC_write_en  (we_s[0]),
        .AR_write_en  (we_s[1]),
        .AC_write_en  (we_s[2]),
        .R_write_en   (we_s[3]),
        .DR_write_en  (we_s[4]),
        .A_write_en   (we_s[5]),
        .B_write_en   (we_s[6]),
        .C_write_en   (we_s[7]),
        .D_write_en   (we_s[8]),
        .TR_write_en  (we_s[9]),
        .PC_inc_en    (ie_s[0]),
        .AR_inc_en    (ie_s[1]),
        .AC_inc_en    (ie_s[2]),
        .AC_clr_en    (clr_s),
        .PC_out       (PC_out),
        .AR_out       (AR_out),
        .AC_out       (AC_out),
        .R_out        (R_out),
        .DR_out       (DR_out),
        .A_out        (A_out),
        .B_out        (B_out),
        .C_out        (C_out),
        .D_out        (D_out),
        .TR_out       (TR_out),
        .CID_out      (CID_out),
        .Z_flag       (Z_flag)
`ifdef BUS_WR_CONFLICT_EN
        ,
        .conflict_err (conflict_err),
        .conflict_cnt (conflict_cnt)
`endif
    );

    assign dut_out[0] = PC_out;
    assign dut_out[1] = AR_out;
    assign dut_out[2] = AC_out;
    assign dut_out[3] = R_out;
    assign dut_out[4] = DR_out;
    assign dut_out[5] = A_out;
    assign dut_out[6] = B_out;
    assign dut_out[7] = C_out;
    assign dut_out[8] = D_out;
    assign dut_out[9] = TR_out;

    // Advance the model by one clock using the architectural rules.
    task automatic modelStep(input logic r, input logic [DW-1:0] b,
                             input logic [9:0] we, input logic [2:0] ie,
                             input logic clr);
        logic ac_touched;
        logic conf;
        if (r) begin
            for (int i = 0; i < 10; i++) mdl[i] = '0;
            m_z   = 1'b1;
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            conf = (we[0] & ie[0]) | (we[1] & ie[1]) | (we[2] & ie[2]) |
                   ((we[2] | ie[2]) & clr);
            if (conf) begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
            end
            ac_touched = we[2] | ie[2] | clr;
            for (int i = 0; i < 10; i++) begin
                if (we[i])                 mdl[i] = b;
                else if (i == 2 && clr)    mdl[i] = '0;
                else if (i < 3 && ie[i])   mdl[i] = DW'((int'(mdl[i]) + 1) % 65536);
            end
            if (ac_touched) m_z = (mdl[2] == '0);
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int i = 0; i < 10; i++) begin
            checks++;
            assert (dut_out[i] === mdl[i]) else begin
                errors++;
                $error("[TB] FAIL %s reg%0d: observed %h expected %h", tag, i, dut_out[i], mdl[i]);
            end
        end
        checks++;
        assert (Z_flag === m_z) else begin
            errors++;
            $error("[TB] FAIL %s Z_flag: observed %b expected %b", tag, Z_flag, m_z);
        end
        checks++;
        assert (CID_out === DW'(CORE_ID)) else begin
            errors++;
            $error("[TB] FAIL %s CID_out: observed %h expected %h", tag, CID_out, DW'(CORE_ID));
        end
`ifdef BUS_WR_CONFLICT_EN
        checks++;
        assert (conflict_err === m_err) else begin
            errors++;
            $error("[TB] FAIL %s conflict_err: observed %b expected %b", tag, conflict_err, m_err);
        end
        checks++;
        assert (conflict_cnt === 8'(m_cnt)) else begin
            errors++;
            $error("[TB] FAIL %s conflict_cnt: observed %0d expected %0d", tag, conflict_cnt, m_cnt);
        end
`endif
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare.
    task automatic applyStimulus(input string tag, input logic r, input logic [DW-1:0] b,
                                 input logic [9:0] we, input logic [2:0] ie,
                                 input logic clr);
        rst   = r;
        bus   = b;
        we_s  = we;
        ie_s  = ie;
        clr_s = clr;
        @(posedge clk);
        #1;
        modelStep(r, b, we, ie, clr);
        checkOutput(tag);
    endtask

    initial begin
        logic [DW-1:0] rb;
        logic          rr;

        rst = 1'b1; bus = '0; we_s = '0; ie_s = '0; clr_s = 1'b0;
        for (int i = 0; i < 10; i++) mdl[i] = 'x;
        m_z = 1'bx; m_err = 1'bx; m_cnt = 0;

        $display("[TB] reset with every enable high");
        applyStimulus("reset", 1'b1, 16'hBEEF, 10'h3FF, 3'b111, 1'b1);
        applyStimulus("reset2", 1'b1, 16'h0000, 10'h3FF, 3'b111, 1'b1);

        $display("[TB] broadcast");
        applyStimulus("bcast", 1'b0, 16'h1234, 10'b10_0100_0010, 3'b000, 1'b0);

        $display("[TB] AC wrap");
        applyStimulus("ac_load", 1'b0, 16'hFFFF, 10'b00_0000_0100, 3'b000, 1'b0);
        applyStimulus("ac_wrap", 1'b0, 16'h0000, 10'b00_0000_0000, 3'b100, 1'b0);
        applyStimulus("ac_inc1", 1'b0, 16'h0000, 10'b00_0000_0000, 3'b100, 1'b0);
        applyStimulus("hold",    1'b0, 16'h0000, 10'b00_0000_0000, 3'b000, 1'b0);

        $display("[TB] priority");
        applyStimulus("pc_load", 1'b0, 16'h0010, 10'b00_0000_0001, 3'b000, 1'b0);
        applyStimulus("pc_prio", 1'b0, 16'h00A0, 10'b00_0000_0001, 3'b001, 1'b0);
        applyStimulus("ac_clr",  1'b0, 16'h7777, 10'b00_0000_0000, 3'b100, 1'b1);

        $display("[TB] self-source");
        applyStimulus("ac_55",   1'b0, 16'h0055, 10'b00_0000_0100, 3'b000, 1'b0);
        applyStimulus("ac_self", 1'b0, mdl[2],   10'b00_0000_0100, 3'b000, 1'b0);

        $display("[TB] randomized micro-operations");
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0:       rb = 16'h0000;
                1:       rb = 16'hFFFF;
                default: rb = 16'($urandom);
            endcase
            rr = ($urandom_range(0, 49) == 0);
            applyStimulus("rand", rr, rb, 10'($urandom), 3'($urandom),
                          ($urandom_range(0, 3) == 0));
        end

`ifdef BUS_WR_CONFLICT_EN
        $display("[TB] conflict saturation");
        applyStimulus("sat_rst", 1'b1, 16'h0000, 10'h000, 3'b000, 1'b0);
        for (int n = 0; n < 300; n++) begin
            applyStimulus("sat", 1'b0, 16'($urandom), 10'b00_0000_0001, 3'b001, 1'b0);
        end
        applyStimulus("sat_clr", 1'b1, 16'h0000, 10'h000, 3'b000, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
